dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the RV64 core's load/store path: the memory-side end of the request the memory access stage issues (read/write enable, address, write data).
- Replaces the zero-latency ideal memory with a valid/ready request/response handshake and configurable access latency. This prepares the core for stall-aware memory.
- Holds one outstanding request at a time. Checks alignment and range, and returns read data or an error flag.

Parameters:
- DEPTH, 1024, number of 64-bit doublewords in the array (power of two, >=2)
- LATENCY, 2, cycles from request acceptance to first rsp_valid cycle (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_read  input  1  load request
- req_write  input  1  store request
- req_addr  input  64  byte address (the ALU result)
- req_wdata  input  64  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator consumes the response
- rsp_rdata  output  64  load data; 0 for stores and errors
- rsp_err  output  1  request rejected (misaligned, out of range, or illegal op)

Behaviour:
- Clock and reset: single clock domain, clk; reset is synchronous, active-high, named rst.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Array contents are not cleared by reset.
  - Reset mid-operation aborts the transaction. A pending store does not commit.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid, the request is accepted and its fields are latched.
    - LATENCY=1: go to RESP.
    - Otherwise: go to BUSY with cnt=LATENCY-2.
  - BUSY: req_ready=0. cnt decrements each cycle. At the edge where cnt==0, go to RESP.
  - RESP: req_ready=0, rsp_valid=1, and rsp_rdata/rsp_err are stable.
    - rsp_valid&&rsp_ready returns to IDLE.
    - Otherwise RESP holds indefinitely (backpressure).
- Latency: request accepted in cycle c means rsp_valid is first high in cycle c+LATENCY. Minimum request-to-request interval is LATENCY+1 cycles.
- Access commit: the array read/write happens at the edge entering RESP.
  - Stores write the full doubleword at index req_addr[3+log2(DEPTH)-1:3].
  - Loads capture the array word into rsp_rdata.
  - A load after a store to the same address returns the stored value.
- Error checks, evaluated on the latched request:
  - req_addr[2:0]!=0: misaligned.
  - req_addr>>3 >= DEPTH: out of range.
  - req_read&&req_write: illegal op.
  - req_read==req_write==0: treated as a no-op store, rsp_err=0, nothing written.
  - On any error: no array write, rsp_rdata=0, rsp_err=1.
- Request inputs are ignored outside IDLE. The initiator must hold them stable only in the accepting cycle.
- rsp_rdata and rsp_err are 0 whenever rsp_valid=0.

Optional Feature:
- DMEM_WSTRB_EN defined: adds port req_wstrb input 8, byte-enables for stores.
  - Only lanes with wstrb[i]=1 (bits 8i+7:8i) are written.
  - Alignment is still checked on doublewords.
  - wstrb=0 on a store is a legal no-op with rsp_err=0.
- DMEM_WSTRB_EN undefined: no req_wstrb port; stores write all 8 bytes.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE/BUSY/RESP)
  - XLEN=64
  - DW_BYTES=8
  - error-cause localparams for the bench
- Sub-module dmem_array:
  - synchronous single-port DEPTH x 64 storage
  - write-enable plus optional byte strobe
  - registered read
- The FSM, counter and checks stay in dmem_responder.

Test Plan:
- Reset held 3 cycles mid-BUSY with store pending -> after release rsp_valid=0, req_ready=1; a load of the same address returns the prior value.
- LATENCY=2: store 0xDEADBEEF_CAFEF00D to 0x40 in cycle 0 -> rsp_valid high in cycle 2, rsp_err=0. A load of 0x40 then returns 0xDEADBEEF_CAFEF00D exactly LATENCY cycles after acceptance.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored. Raising rsp_ready gives req_ready=1 the next cycle.
- Load at 0x44 (misaligned) and at DEPTH*8 (out of range) -> rsp_err=1, rsp_rdata=0, array unchanged.
- req_read=req_write=1 at 0x08 -> rsp_err=1, no write (a load of 0x08 returns its old value).
- DMEM_WSTRB_EN: store 0xFFFF_FFFF_FFFF_FFFF wstrb=0x0F over 0x0 -> load of 0x0 returns 0x0000_0000_FFFF_FFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional byte-strobe stores are enabled with the DMEM_WSTRB_EN macro.
package dmem_pkg;

    localparam int XLEN     = 64;
    localparam int DW_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Rejection causes, highest priority first; ERR_NONE means the access is legal.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 64-bit storage with per-byte write strobes and a registered read.
// Contents are uninitialised; the responder only exposes words it has selected.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DW_BYTES-1:0] wstrb,
    input  logic [AW-1:0]       addr,
    input  logic [XLEN-1:0]     wdata,
    output logic [XLEN-1:0]     rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset branch on purpose; clearing a RAM
    // would need a per-word reset network and turn it into flops.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DW_BYTES; i++) begin
                    if (wstrb[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: one outstanding request, fixed LATENCY, alignment/range checks.
// Define DMEM_WSTRB_EN to add the req_wstrb byte-enable port for stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_read,
    input  logic                req_write,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
`ifdef DMEM_WSTRB_EN
    input  logic [DW_BYTES-1:0] req_wstrb,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    state_t              state, next_state;
    logic [CW-1:0]       cnt;

    logic                read_q, write_q;
    logic [XLEN-1:0]     addr_q, wdata_q;
    logic [DW_BYTES-1:0] wstrb_q, wstrb_in;

    logic                cur_read, cur_write;
    logic [XLEN-1:0]     cur_addr, cur_wdata;
    logic [DW_BYTES-1:0] cur_wstrb;
    logic [1:0]          cause;
    logic                enter_resp, mem_en, mem_we, load_ok;
    logic [XLEN-1:0]     mem_rdata;

`ifdef DMEM_WSTRB_EN
    assign wstrb_in = req_wstrb;
`else
    assign wstrb_in = '1;
`endif

    // With LATENCY=1 the array is accessed on the accepting edge, so the live
    // inputs stand in for the not-yet-latched request while in IDLE.
    always_comb begin
        if (state == IDLE) begin
            cur_read  = req_read;
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_wstrb = wstrb_in;
        end else begin
            cur_read  = read_q;
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_wstrb = wstrb_q;
        end
    end

    always_comb begin
        cause = ERR_NONE;
        if (cur_addr[2:0] != 3'b000) begin
            cause = ERR_MISALIGN;
        end else if (|cur_addr[XLEN-1:AW+3]) begin
            cause = ERR_RANGE;
        end else if (cur_read && cur_write) begin
            cause = ERR_ILLEGAL;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_valid) next_state = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (cnt == '0) next_state = RESP;
            RESP: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                cnt <= CNT_INIT;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            read_q  <= req_read;
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= wstrb_in;
        end
    end

    // The array is touched only on the edge entering RESP, and never under
    // reset, so an aborted store leaves memory untouched.
    assign enter_resp = (state != RESP) && (next_state == RESP);
    assign mem_en     = enter_resp && !rst;
    assign mem_we     = mem_en && cur_write && !cur_read && (cause == ERR_NONE);
    assign load_ok    = cur_read && !cur_write && (cause == ERR_NONE);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .wstrb (cur_wstrb),
        .addr  (cur_addr[AW+2:3]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && (cause != ERR_NONE);
    assign rsp_rdata = (rsp_valid && load_ok) ? mem_rdata : '0;

endmodule
